// File: rtl/forwarding_if.sv
// Operand-bypass bundle between a pipeline stage and its forwarding unit.
// master: the consumer stage / pipeline registers that drive the request and entry fields.
// slave:  the forwarding unit, which returns the resolved operand, source code, stall and
//         the stall-cycle counter.
interface forwarding_if;
  // Request
  logic [4:0]  required_reg;
  logic [31:0] gpr_result;
  logic [2:0]  required_stage;
  logic [2:0]  pipeline_stage;
  // Value being produced in MEM this cycle
  logic        memory_forwarding_enabled;
  logic [31:0] memory_forwarding_result;
  // ID/EX entry
  logic        ex_write_enabled;
  logic [4:0]  ex_write_register;
  logic [2:0]  ex_ready_stage;
  logic [31:0] ex_result;
  // EX/MEM entry
  logic        mem_write_enabled;
  logic [4:0]  mem_write_register;
  logic [2:0]  mem_ready_stage;
  logic [31:0] mem_result;
  // MEM/WB entry
  logic        wb_write_enabled;
  logic [4:0]  wb_write_register;
  logic [2:0]  wb_ready_stage;
  logic [31:0] wb_result;
  // Responses
  logic [31:0] forwarding_result;
  logic        stall;
  logic [2:0]  forwarding_signal;
  logic [31:0] stall_cycles;

  modport master (
    output required_reg, gpr_result, required_stage, pipeline_stage,
           memory_forwarding_enabled, memory_forwarding_result,
           ex_write_enabled, ex_write_register, ex_ready_stage, ex_result,
           mem_write_enabled, mem_write_register, mem_ready_stage, mem_result,
           wb_write_enabled, wb_write_register, wb_ready_stage, wb_result,
    input  forwarding_result, stall, forwarding_signal, stall_cycles
  );

  modport slave (
    input  required_reg, gpr_result, required_stage, pipeline_stage,
           memory_forwarding_enabled, memory_forwarding_result,
           ex_write_enabled, ex_write_register, ex_ready_stage, ex_result,
           mem_write_enabled, mem_write_register, mem_ready_stage, mem_result,
           wb_write_enabled, wb_write_register, wb_ready_stage, wb_result,
    output forwarding_result, stall, forwarding_signal, stall_cycles
  );
endinterface

// File: rtl/forwarding_unit.sv
// Operand bypass and hazard detection for one GPR source operand.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; clears stall_cycles
//   bus   - forwarding_if.slave: request, ID/EX, EX/MEM, MEM/WB entries and memory path in;
//           forwarding_result, forwarding_signal, stall (combinational) and
//           stall_cycles (registered) out.
module forwarding_unit (
  input logic        clock,
  input logic        reset,
  forwarding_if.slave bus
);

  localparam logic [2:0] StageExecute   = 3'd2;
  localparam logic [2:0] StageMemory    = 3'd3;
  localparam logic [2:0] StageWriteback = 3'd4;
  localparam logic [2:0] StageNone      = 3'd7;

  localparam logic [2:0] SrcRegfile  = 3'b000;
  localparam logic [2:0] SrcIdEx     = 3'b001;
  localparam logic [2:0] SrcExMem    = 3'b010;
  localparam logic [2:0] SrcMemWb    = 3'b011;
  localparam logic [2:0] SrcMemPath  = 3'b100;
  localparam logic [2:0] SrcDeferred = 3'b111;

  logic        reg_nonzero;
  logic        match_ex, match_mem, match_wb;
  logic        holds_ex, holds_mem, holds_wb;
  logic        mem_path_ok;
  logic        defer;
  logic [31:0] result_d;
  logic [2:0]  signal_d;
  logic        stall_d;
  logic [31:0] stall_cycles_q;

  assign reg_nonzero = (bus.required_reg != 5'd0);

  // Write enable is tested first so X fields of a bubble entry cannot produce a match.
  assign match_ex  = bus.ex_write_enabled  && (bus.ex_write_register  == bus.required_reg) &&
                     reg_nonzero;
  assign match_mem = bus.mem_write_enabled && (bus.mem_write_register == bus.required_reg) &&
                     reg_nonzero;
  assign match_wb  = bus.wb_write_enabled  && (bus.wb_write_register  == bus.required_reg) &&
                     reg_nonzero;

  // An entry already holds its value if it was produced before the stage that holds it.
  assign holds_ex  = (bus.ex_ready_stage  < StageExecute);
  assign holds_mem = (bus.mem_ready_stage < StageMemory);
  assign holds_wb  = (bus.wb_ready_stage  < StageWriteback);

  assign mem_path_ok = (bus.mem_ready_stage == StageMemory) && bus.memory_forwarding_enabled &&
                       (bus.required_stage == bus.pipeline_stage);

  // Operand not needed until a later stage: that stage re-resolves it.
  assign defer = (bus.required_stage > bus.pipeline_stage);

  always_comb begin
    result_d = bus.gpr_result;
    signal_d = SrcRegfile;
    stall_d  = 1'b0;
    if (!reg_nonzero || (bus.required_stage == StageNone)) begin
      result_d = reg_nonzero ? bus.gpr_result : 32'd0;
    end else if (match_ex) begin
      if (holds_ex) begin
        result_d = bus.ex_result;
        signal_d = SrcIdEx;
      end else begin
        signal_d = SrcDeferred;
        stall_d  = !defer;
      end
    end else if (match_mem) begin
      if (holds_mem) begin
        result_d = bus.mem_result;
        signal_d = SrcExMem;
      end else if (mem_path_ok) begin
        result_d = bus.memory_forwarding_result;
        signal_d = SrcMemPath;
      end else begin
        signal_d = SrcDeferred;
        stall_d  = !defer;
      end
    end else if (match_wb) begin
      if (holds_wb) begin
        result_d = bus.wb_result;
        signal_d = SrcMemWb;
      end else begin
        signal_d = SrcDeferred;
        stall_d  = !defer;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
    end else if (stall_d) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.forwarding_result = result_d;
  assign bus.forwarding_signal = signal_d;
  assign bus.stall             = stall_d;
  assign bus.stall_cycles      = stall_cycles_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: each step pushes its expected outputs to a scoreboard
// queue, then pops and compares them against the DUT away from the clock edge.
module tb_forwarding_unit;

  localparam logic [2:0] Decode    = 3'd1;
  localparam logic [2:0] Execute   = 3'd2;
  localparam logic [2:0] Memory    = 3'd3;
  localparam logic [2:0] Writeback = 3'd4;
  localparam logic [2:0] NoneStage = 3'd7;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic [2:0]  signal;
    logic        stall;
    logic [31:0] cycles;
  } exp_t;

  logic clock;
  logic reset;
  forwarding_if bus ();

  exp_t sb[$];
  int   passed;
  int   total;

  forwarding_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    bus.required_reg              = 5'd0;
    bus.gpr_result                = 32'd0;
    bus.required_stage            = Execute;
    bus.pipeline_stage            = Decode;
    bus.memory_forwarding_enabled = 1'b0;
    bus.memory_forwarding_result  = 32'd0;
    bus.ex_write_enabled          = 1'b0;
    bus.ex_write_register         = 5'd0;
    bus.ex_ready_stage            = Execute;
    bus.ex_result                 = 32'd0;
    bus.mem_write_enabled         = 1'b0;
    bus.mem_write_register        = 5'd0;
    bus.mem_ready_stage           = Memory;
    bus.mem_result                = 32'd0;
    bus.wb_write_enabled          = 1'b0;
    bus.wb_write_register         = 5'd0;
    bus.wb_ready_stage            = Writeback;
    bus.wb_result                 = 32'd0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] result, input logic [2:0] signal,
                          input logic stall, input logic [31:0] cycles);
    exp_t e;
    e.tag = tag; e.result = result; e.signal = signal; e.stall = stall; e.cycles = cycles;
    sb.push_back(e);
  endtask

  task automatic check_one(input string tag, input string field, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    assert (sb.size() > 0) passed++;
    else begin
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    check_one(e.tag, "result", bus.forwarding_result, e.result);
    check_one(e.tag, "signal", {29'd0, bus.forwarding_signal}, {29'd0, e.signal});
    check_one(e.tag, "stall", {31'd0, bus.stall}, {31'd0, e.stall});
    check_one(e.tag, "cycles", bus.stall_cycles, e.cycles);
  endtask

  // Inputs are already driven; push the expectation and sample 1 ns later.
  task automatic step(input string tag, input logic [31:0] result, input logic [2:0] signal,
                      input logic stall, input logic [31:0] cycles);
    push_exp(tag, result, signal, stall, cycles);
    #1;
    pop_check();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // No match after reset
    bus.required_reg = 5'd5;
    bus.gpr_result   = 32'h1234;
    step("no_match", 32'h1234, 3'b000, 1'b0, 32'd0);

    // ID/EX beats MEM/WB on the same register
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd8; bus.gpr_result = 32'h5555;
    bus.ex_write_enabled = 1'b1; bus.ex_write_register = 5'd8;
    bus.ex_ready_stage = Decode; bus.ex_result = 32'hAAAA;
    bus.wb_write_enabled = 1'b1; bus.wb_write_register = 5'd8;
    bus.wb_ready_stage = Memory; bus.wb_result = 32'hBBBB;
    step("priority", 32'hAAAA, 3'b001, 1'b0, 32'd0);

    // Only MEM/WB matches
    @(negedge clock);
    bus.ex_write_enabled = 1'b0;
    step("memwb", 32'hBBBB, 3'b011, 1'b0, 32'd0);

    // EX/MEM holds an ALU result
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd6; bus.gpr_result = 32'h1111;
    bus.mem_write_enabled = 1'b1; bus.mem_write_register = 5'd6;
    bus.mem_ready_stage = Execute; bus.mem_result = 32'hCCCC;
    step("exmem", 32'hCCCC, 3'b010, 1'b0, 32'd0);

    // Load-use stall held three cycles
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd3; bus.gpr_result = 32'h3333;
    bus.required_stage = Execute; bus.pipeline_stage = Execute;
    bus.mem_write_enabled = 1'b1; bus.mem_write_register = 5'd3;
    bus.mem_ready_stage = Memory; bus.mem_result = 32'hEEEE;
    step("load_use", 32'h3333, 3'b111, 1'b1, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      step("load_use_hold", 32'h3333, 3'b111, 1'b1, i);
    end

    // Memory path resolves the same load without a stall
    bus.memory_forwarding_enabled = 1'b1;
    bus.memory_forwarding_result  = 32'hDEAD;
    step("mem_path", 32'hDEAD, 3'b100, 1'b0, 32'd3);

    // Memory path is not used when the operand is needed later
    @(negedge clock);
    bus.pipeline_stage = Decode;
    step("mem_path_later", 32'h3333, 3'b111, 1'b0, 32'd3);

    // Deferred: ID/EX result produced in EXECUTE, consumer in DECODE
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd4; bus.gpr_result = 32'h4444;
    bus.required_stage = Execute; bus.pipeline_stage = Decode;
    bus.ex_write_enabled = 1'b1; bus.ex_write_register = 5'd4;
    bus.ex_ready_stage = Execute; bus.ex_result = 32'h9999;
    step("deferred", 32'h4444, 3'b111, 1'b0, 32'd3);

    // Operand unused
    @(negedge clock);
    bus.required_stage = NoneStage;
    step("unused", 32'h4444, 3'b000, 1'b0, 32'd3);

    // X on a bubble entry must not leak
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd12; bus.gpr_result = 32'h0C0C;
    bus.wb_write_enabled = 1'b0; bus.wb_write_register = 'x;
    bus.wb_ready_stage = 'x; bus.wb_result = 'x;
    step("bubble_x", 32'h0C0C, 3'b000, 1'b0, 32'd3);

    // Register zero is forced to 0 even when written
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd0; bus.gpr_result = 32'hFFFF_FFFF;
    bus.ex_write_enabled = 1'b1; bus.ex_write_register = 5'd0;
    bus.ex_ready_stage = Decode; bus.ex_result = 32'h7777;
    step("reg_zero", 32'd0, 3'b000, 1'b0, 32'd3);

    // Younger non-ready ID/EX match hides an older holding MEM/WB match
    @(negedge clock);
    clear_inputs();
    bus.required_reg = 5'd9; bus.gpr_result = 32'h0909;
    bus.required_stage = Execute; bus.pipeline_stage = Execute;
    bus.ex_write_enabled = 1'b1; bus.ex_write_register = 5'd9; bus.ex_ready_stage = Memory;
    bus.wb_write_enabled = 1'b1; bus.wb_write_register = 5'd9;
    bus.wb_ready_stage = Execute; bus.wb_result = 32'hB0B0;
    step("shadow_stall", 32'h0909, 3'b111, 1'b1, 32'd3);

    // Reset wins over increment while stalled
    reset = 1'b1;
    @(negedge clock);
    step("reset_in_stall", 32'h0909, 3'b111, 1'b1, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    step("count_after_reset", 32'h0909, 3'b111, 1'b1, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
